// File: rtl/cpu_bus_arbiter_n.sv
// Round-robin arbiter multiplexing CHANNELS read/write clients onto one shared
// external memory bus, with external-ownership back-off and per-access timeout.
module cpu_bus_arbiter_n #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  localparam int unsigned IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          ch_read_q,
  input  logic [CHANNELS-1:0]          ch_write_q,
  input  logic [CHANNELS*ADDR_W-1:0]   ch_addr,
  input  logic [CHANNELS*DATA_W-1:0]   ch_wdata,
  output logic [CHANNELS-1:0]          ch_done,
  output logic [CHANNELS-1:0]          ch_err,
  output logic [DATA_W-1:0]            rdata,
  output logic [IDX_W-1:0]             grant_idx,
  input  logic                         bus_busy_in,
  output logic                         bus_busy_out,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [DATA_W-1:0]            data_out,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         read_q,
  output logic                         write_q,
  input  logic                         read_dn,
  input  logic                         write_dn
);

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    last;
  logic [TO_W-1:0]     count;
  logic                op_write;
  logic [CHANNELS-1:0] req;
  logic                found;
  logic [IDX_W-1:0]    winner;
  logic [CHANNELS-1:0] grant_oh;
  logic                dn_seen;

  // First requester after the previous winner, wrapping modulo CHANNELS.
  always_comb begin
    req    = ch_read_q | ch_write_q;
    found  = 1'b0;
    winner = last;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(last) + k) % CHANNELS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant_oh = CHANNELS'(1) << grant_idx;
  // Only the completion that matches the latched op ends the access.
  assign dn_seen  = op_write ? write_dn : read_dn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IDX_W'(CHANNELS - 1);
      count        <= '0;
      op_write     <= 1'b0;
      ch_done      <= '0;
      ch_err       <= '0;
      rdata        <= '0;
      grant_idx    <= '0;
      bus_busy_out <= 1'b0;
      addr_out     <= '0;
      data_out     <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
    end else begin
      ch_done <= '0;
      ch_err  <= '0;
      case (state)
        IDLE: begin
          if (found && !bus_busy_in) begin
            grant_idx    <= winner;
            last         <= winner;
            addr_out     <= ch_addr[32'(winner)*ADDR_W +: ADDR_W];
            data_out     <= ch_wdata[32'(winner)*DATA_W +: DATA_W];
            op_write     <= ch_write_q[winner];
            write_q      <= ch_write_q[winner];
            read_q       <= !ch_write_q[winner];
            bus_busy_out <= 1'b1;
            count        <= '0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          count <= count + TO_W'(1);
          if (dn_seen) begin
            if (!op_write) rdata <= data_in;
            ch_done      <= grant_oh;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            bus_busy_out <= 1'b0;
            state        <= RELEASE;
          end else if (TO_EN && count == TO_LIMIT) begin
            ch_err       <= grant_oh;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            bus_busy_out <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter_n.sv
// Directed bench for cpu_bus_arbiter_n: completions checked through a scoreboard,
// bus-side behaviour checked inline at each step.
module tb_cpu_bus_arbiter_n;

  localparam int CH = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     ch_read_q, ch_write_q;
  logic [CH*AW-1:0]  ch_addr;
  logic [CH*DW-1:0]  ch_wdata;
  logic [CH-1:0]     ch_done, ch_err;
  logic [DW-1:0]     rdata;
  logic [1:0]        grant_idx;
  logic              bus_busy_in, bus_busy_out;
  logic [AW-1:0]     addr_out;
  logic [DW-1:0]     data_out, data_in;
  logic              read_q, write_q, read_dn, write_dn;

  cpu_bus_arbiter_n #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .ch_read_q(ch_read_q), .ch_write_q(ch_write_q),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_done(ch_done), .ch_err(ch_err), .rdata(rdata), .grant_idx(grant_idx),
    .bus_busy_in(bus_busy_in), .bus_busy_out(bus_busy_out),
    .addr_out(addr_out), .data_out(data_out), .data_in(data_in),
    .read_q(read_q), .write_q(write_q), .read_dn(read_dn), .write_dn(write_dn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [CH-1:0] done;
    logic [CH-1:0] err;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [CH-1:0] done, input logic [CH-1:0] err,
                      input logic is_read, input logic [DW-1:0] data);
    exp_t e;
    e.done = done; e.err = err; e.is_read = is_read; e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every done/err pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ch_done != '0 || ch_err != '0)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'({ch_err, ch_done}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_done", 64'(ch_done), 64'(e.done));
        check("sb_err", 64'(ch_err), 64'(e.err));
        if (e.is_read) check("sb_rdata", 64'(rdata), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_read_q = '0; ch_write_q = '0; ch_addr = '0; ch_wdata = '0;
    bus_busy_in = 1'b0; data_in = '0; read_dn = 1'b0; write_dn = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_addr[ch*AW +: AW]  = a;
    ch_wdata[ch*DW +: DW] = d;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    clear_inputs();
    do_reset();
    check("rst_done", 64'(ch_done), 64'd0);
    check("rst_err", 64'(ch_err), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_busy", 64'(bus_busy_out), 64'd0);
    check("rst_strobes", 64'({read_q, write_q}), 64'd0);
    check("rst_addr", 64'(addr_out), 64'd0);

    // Single read on ch0, read_dn two cycles after the strobe.
    set_ch(0, 32'h100, 32'h0);
    ch_read_q[0] = 1'b1;
    push(4'b0001, 4'b0000, 1'b1, 32'hDEADBEEF);
    step();
    check("t1_read_q", 64'(read_q), 64'd1);
    check("t1_write_q", 64'(write_q), 64'd0);
    check("t1_addr", 64'(addr_out), 64'h100);
    check("t1_busy", 64'(bus_busy_out), 64'd1);
    step();
    check("t1_hold", 64'(read_q), 64'd1);
    check("t1_nodone", 64'(ch_done), 64'd0);
    read_dn = 1'b1; data_in = 32'hDEADBEEF;
    step();
    check("t1_done", 64'(ch_done), 64'b0001);
    check("t1_rdata", 64'(rdata), 64'hDEADBEEF);
    check("t1_rel_busy", 64'(bus_busy_out), 64'd0);
    check("t1_rel_read_q", 64'(read_q), 64'd0);
    ch_read_q = '0; read_dn = 1'b0; data_in = '0;
    step();
    check("t1_done_once", 64'(ch_done), 64'd0);

    // All channels writing continuously: round-robin order from reset.
    do_reset();
    for (int i = 0; i < CH; i++) set_ch(i, 32'h1000 * (i + 1), 32'hA000_0000 + i);
    ch_write_q = 4'hF;
    write_dn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_grant", 64'(grant_idx), 64'(order[i]));
      check("t2_write_q", 64'(write_q), 64'd1);
      check("t2_data", 64'(data_out), 64'(32'hA000_0000 + order[i]));
      check("t2_addr", 64'(addr_out), 64'(32'h1000 * (order[i] + 1)));
      push(4'(1 << order[i]), 4'b0000, 1'b0, 32'h0);
      step();
      check("t2_rel", 64'({bus_busy_out, write_q}), 64'd0);
      if (i == 4) begin
        ch_write_q = '0;
        write_dn = 1'b0;
      end
      step();
    end

    // External owner holds the bus for 10 cycles.
    do_reset();
    bus_busy_in = 1'b1;
    set_ch(2, 32'h300, 32'h0);
    ch_read_q[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_blocked", 64'({bus_busy_out, read_q, write_q}), 64'd0);
    end
    bus_busy_in = 1'b0;
    push(4'b0100, 4'b0000, 1'b1, 32'h12345678);
    step();
    check("t3_start", 64'(read_q), 64'd1);
    check("t3_grant", 64'(grant_idx), 64'd2);
    check("t3_addr", 64'(addr_out), 64'h300);
    read_dn = 1'b1; data_in = 32'h12345678;
    step();
    ch_read_q = '0; read_dn = 1'b0; data_in = '0;
    step();

    // Timeout on ch1 read: four strobe cycles, then an error pulse.
    set_ch(1, 32'h200, 32'h0);
    ch_read_q[1] = 1'b1;
    push(4'b0000, 4'b0010, 1'b0, 32'h0);
    step();
    check("t4_grant", 64'(grant_idx), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("t4_read_q_high", 64'(read_q), 64'd1);
      if (i < 3) step();
    end
    step();
    check("t4_read_q_low", 64'(read_q), 64'd0);
    check("t4_err", 64'(ch_err), 64'b0010);
    check("t4_nodone", 64'(ch_done), 64'd0);
    check("t4_rdata_kept", 64'(rdata), 64'h12345678);
    ch_read_q = '0;
    step();
    check("t4_err_once", 64'(ch_err), 64'd0);

    // Read+write on ch3 is a write; stray read_dn is ignored.
    set_ch(3, 32'h20, 32'hCAFE0003);
    ch_read_q[3] = 1'b1; ch_write_q[3] = 1'b1;
    step();
    check("t5_write_q", 64'(write_q), 64'd1);
    check("t5_read_q", 64'(read_q), 64'd0);
    check("t5_addr", 64'(addr_out), 64'h20);
    check("t5_data", 64'(data_out), 64'hCAFE0003);
    read_dn = 1'b1;
    step();
    check("t5_ignore_rdn", 64'(write_q), 64'd1);
    check("t5_nodone", 64'(ch_done), 64'd0);
    read_dn = 1'b0;
    step();
    check("t5_still", 64'(write_q), 64'd1);
    write_dn = 1'b1;
    push(4'b1000, 4'b0000, 1'b0, 32'h0);
    step();
    check("t5_write_q_low", 64'(write_q), 64'd0);
    ch_read_q = '0; ch_write_q = '0; write_dn = 1'b0;
    step();

    // write_dn on the timeout-limit cycle counts as done.
    set_ch(0, 32'h40, 32'h55AA55AA);
    ch_write_q[0] = 1'b1;
    step();
    check("t6_grant", 64'(grant_idx), 64'd0);
    step(); step(); step();
    check("t6_hold", 64'(write_q), 64'd1);
    write_dn = 1'b1;
    push(4'b0001, 4'b0000, 1'b0, 32'h0);
    step();
    check("t6_done", 64'(ch_done), 64'b0001);
    check("t6_noerr", 64'(ch_err), 64'd0);
    ch_write_q = '0; write_dn = 1'b0;
    step();

    // Asynchronous reset mid-access, then channel 0 wins first.
    set_ch(2, 32'h300, 32'h0);
    ch_read_q[2] = 1'b1;
    step();
    check("t7_access", 64'(read_q), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t7_async_drop", 64'({bus_busy_out, read_q, write_q}), 64'd0);
    clear_inputs();
    step();
    rst = 1'b0;
    ch_read_q = 4'hF;
    for (int i = 0; i < CH; i++) set_ch(i, 32'h400 + i, 32'h0);
    step();
    check("t7_first_grant", 64'(grant_idx), 64'd0);
    check("t7_addr", 64'(addr_out), 64'h400);
    ch_read_q = '0;
    read_dn = 1'b1; data_in = 32'hA5A5A5A5;
    push(4'b0001, 4'b0000, 1'b1, 32'hA5A5A5A5);
    step();
    read_dn = 1'b0; data_in = '0;
    step();
    step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter_n.md
Name: cpu_bus_arbiter_n

Overview:
N-channel successor to the single-client CPU bus bridge. Multiplexes read/write requests from CHANNELS internal clients (fetch, operand, store, message units) onto the one shared external memory bus of a CPU. Uses round-robin fairness, honours external bus ownership (bus_busy_in), and adds a per-access timeout with error reporting.

Parameters:
CHANNELS, 4, number of client request channels (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, cycles allowed in ACCESS before abort; 0 disables timeout
TO_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
ch_read_q  in  CHANNELS  per-channel read request, level
ch_write_q  in  CHANNELS  per-channel write request, level
ch_addr  in  CHANNELS*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
ch_wdata  in  CHANNELS*DATA_W  per-channel write data, packed the same way
ch_done  out  CHANNELS  one-cycle completion pulse, one-hot
ch_err  out  CHANNELS  one-cycle timeout pulse, one-hot
rdata  out  DATA_W  last read data; valid while ch_done is high
grant_idx  out  $clog2(CHANNELS)  index of the channel currently or last served
bus_busy_in  in  1  shared bus owned by another agent
bus_busy_out  out  1  this CPU owns the bus
addr_out  out  ADDR_W  bus address
data_out  out  DATA_W  bus write data
data_in  in  DATA_W  bus read data
read_q  out  1  bus read strobe
write_q  out  1  bus write strobe
read_dn  in  1  read complete
write_dn  in  1  write complete

Behaviour:
- Clock, reset: one clock, clk. rst is asynchronous and active-high. All outputs are registered.
- Reset values: all outputs 0. State = IDLE. Round-robin pointer last = CHANNELS-1, so channel 0 wins first. Timeout counter = 0.
- Reset mid-access drops read_q, write_q and bus_busy_out immediately (asynchronously). Any pending done/err is lost.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - bus_busy_in is sampled only in this state.
  - If any channel requests and bus_busy_in=0, pick the first requesting channel scanning last+1, last+2, ... modulo CHANNELS.
  - Latch its address, write data and op into addr_out, data_out and grant_idx. Set last = winner.
  - Set bus_busy_out=1 and read_q or write_q=1, then go to ACCESS.
  - If bus_busy_in=1 or no request, stay in IDLE with outputs unchanged.
- Op selection: a channel with both ch_read_q and ch_write_q high is served as a write.
- ACCESS:
  - Hold addr_out, data_out, strobe and bus_busy_out stable. Increment the timeout counter each cycle.
  - Read op with read_dn=1: rdata <= data_in, ch_done[grant]=1, drop read_q, go to RELEASE.
  - Write op with write_dn=1: ch_done[grant]=1, drop write_q, go to RELEASE.
  - read_dn during a write, or write_dn during a read, is ignored.
  - If TIMEOUT!=0, dn is not seen and counter==TIMEOUT-1: ch_err[grant]=1, drop the strobe, go to RELEASE. rdata is unchanged.
  - dn seen on the same cycle as the timeout limit counts as done, not error.
- RELEASE: exactly one cycle. bus_busy_out=0, strobes=0. ch_done/ch_err are high during this cycle only. Counter is cleared. Go to IDLE.
- Requester contract: hold the request until it sees ch_done or ch_err, then deassert it at the next edge. IDLE sees the deasserted level, so there is no double service.
- Latency: request present in IDLE with bus free at edge 0.
  - Edge 1: strobe and bus_busy_out high.
  - dn sampled at edge k: done high from edge k until edge k+1.
  - Minimum 3 cycles request-to-IDLE with same-cycle dn.
- Fairness: a continuously requesting channel waits at most CHANNELS-1 other accesses.
- Requests changing while in ACCESS/RELEASE do not affect the current access.

Test Plan:
- Reset, then ch0 read addr 0x100, read_dn after 2 cycles with data_in=0xDEADBEEF -> read_q=1 and addr_out=0x100 one edge after request; ch_done=0001 for one cycle; rdata=0xDEADBEEF; bus_busy_out low in RELEASE.
- All 4 channels request writes continuously, write_dn=1 immediately -> grant order 0,1,2,3,0; each channel's data_out matches its ch_wdata; ch_done one-hot each time.
- ch2 requests while bus_busy_in=1 for 10 cycles -> no strobe and bus_busy_out=0 throughout; access starts one edge after bus_busy_in falls.
- TIMEOUT=4, ch1 read, no read_dn -> read_q high exactly 4 cycles; ch_err=0010 one cycle; ch_done stays 0; rdata unchanged.
- ch3 asserts read+write with addr 0x20 -> write_q=1, read_q=0; read_dn pulses are ignored until write_dn arrives.
- Async rst mid-ACCESS -> read_q, write_q and bus_busy_out go 0 without a clock edge; after release, channel 0 wins first.
